serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It is the sequential successor to the single-bit half-adder cell. It reuses one 1-bit full-adder cell plus a carry flip-flop to add or subtract two WIDTH-bit operands over WIDTH clock cycles. It uses a Start/Busy/Done handshake. It is intended as the low-area arithmetic block for the combinational/sequential arithmetic library.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with Start
A  input  WIDTH  operand A; sampled with Start
B  input  WIDTH  operand B; sampled with Start
Busy  output  1  high while an operation is in progress (RUN and DONE states)
Done  output  1  one-cycle pulse marking that results are valid
Sum  output  WIDTH  result, registered, held until the next completion
Cout  output  1  final carry out; for subtract, 1 = no borrow, 0 = borrow
Overflow  output  1  two's-complement overflow (carry into MSB XOR Cout)

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, and all of the following are 0: Busy, Done, Sum, Cout, Overflow, bit counter, carry FF and the operand shift registers. Reset overrides every other input. A reset in the middle of an operation aborts it: no Done pulse, outputs cleared, and the next Start behaves normally.
- State machine IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - Busy=0, Done=0.
  - On an edge with Start=1: load shift-A = A, and load shift-B = B (Mode=0) or ~B (Mode=1).
  - Set carry FF = Mode and counter = 0, then go to RUN.
  - Start=0: stay in IDLE.
- RUN, one bit per edge, LSB first:
  - s = a0^b0^c and cnext = majority(a0,b0,c), computed via the full_adder cell.
  - The sum shift register shifts right with s inserted at the MSB. shift-A and shift-B shift right.
  - carry FF <= cnext. On the bit where counter = WIDTH-1, also latch the carry-in of that bit as msb_cin.
  - On the edge processing counter = WIDTH-1: Sum <= final sum word, Cout <= cnext, Overflow <= msb_cin ^ cnext. Go to DONE.
  - Otherwise counter increments.
- DONE: Done=1 and Busy=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: if Start is sampled at edge k, Done is high in the cycle between edges k+WIDTH and k+WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Start while Busy=1, including the DONE cycle, is ignored and not queued.
- A, B and Mode are captured only at acceptance. Changes during RUN have no effect.
- Sum, Cout and Overflow change only on entry to DONE or on reset. Partial sums are never visible on the outputs.
- WIDTH=1: RUN lasts one edge, and Overflow = cin ^ cout of that single bit.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module, full_adder: a combinational 1-bit cell with ports A, B, Cin, Sum, Cout, instantiated once.
- Counter width is $clog2(WIDTH) with a minimum of 1, computed locally.

Test Plan:
1. Reset: assert rst for 2 cycles with Start=1 -> Busy=0, Done=0, Sum=0, Cout=0, Overflow=0. Release -> IDLE, and no operation starts until a new Start.
2. Add, WIDTH=8:
   - A=100, B=27, Mode=0 -> Done exactly 8 edges after the Start edge, Sum=127, Cout=0, Overflow=0.
   - A=8'hFF, B=8'h01 -> Sum=8'h00, Cout=1, Overflow=0.
3. Signed overflow:
   - A=8'h7F, B=8'h01, Mode=0 -> Sum=8'h80, Cout=0, Overflow=1.
   - A=8'h80, B=8'h01, Mode=1 -> Sum=8'h7F, Cout=1, Overflow=1.
4. Subtract with borrow: A=5, B=7, Mode=1 -> Sum=8'hFE, Cout=0, Overflow=0. Also A=7, B=5 -> Sum=2, Cout=1.
5. Handshake:
   - Hold Start=1 continuously -> operations accepted every 10 cycles (WIDTH+2), each with a single one-cycle Done pulse.
   - Change A and B mid-RUN -> result unaffected.
   - Sum stays stable between Done pulses.
6. Abort and exhaustive check:
   - Assert rst on the 3rd RUN edge -> no Done, outputs 0. The next Start (A=3, B=4) gives Sum=7.
   - WIDTH=4: all 512 (A,B,Mode) combinations checked against a reference model for Sum, Cout and Overflow.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic library blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full-adder cell.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB first over WIDTH cycles, with a Start/Busy/Done handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for Start; operands captured on acceptance
// ST_RUN  | one bit per edge; results latched on the last bit
// ST_DONE | one-cycle Done pulse, results valid
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             Mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] shs_q, shs_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s, fa_c;
   logic [WIDTH-1:0] shs_next;

   full_adder u_fa (
      .A    (sha_q[0]),
      .B    (shb_q[0]),
      .Cin  (carry_q),
      .Sum  (fa_s),
      .Cout (fa_c)
   );

   // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_shs_w1
         assign shs_next = fa_s;
      end else begin : g_shs_wn
         assign shs_next = {fa_s, shs_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      shs_d   = shs_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               sha_d   = A;
               shb_d   = (Mode == MODE_ADD) ? B : ~B;
               carry_d = (Mode == MODE_SUB);
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            shs_d   = shs_next;
            carry_d = fa_c;
            if (cnt_q == LAST_BIT) begin
               // carry_q here is the carry into the MSB
               sum_d   = shs_next;
               cout_d  = fa_c;
               ovf_d   = carry_q ^ fa_c;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sha_q   <= '0;
         shb_q   <= '0;
         shs_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         shs_q   <= shs_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign Done     = (state_q == ST_DONE);
   assign Sum      = sum_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake/arithmetic
// cases and a 4-bit instance swept over every (A, B, Mode) combination.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8, mode8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start4, mode4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] prev8 = 8'h00;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .Start(start8), .Mode(mode8), .A(a8), .B(b8),
      .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8), .Overflow(ovf8)
   );

   serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .Start(start4), .Mode(mode4), .A(a4), .B(b4),
      .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle8();
      int k = 0;
      while (busy8 && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic m, input logic [7:0] es, input logic ec,
                      input logic eo, input bit perturb);
      int n = 0;
      bit stable = 1'b1;
      wait_idle8();
      @(negedge clk);
      a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      start8 = 1'b0;
      while (!done8 && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (perturb && n == 3) begin
            a8 = ~a8; b8 = 8'h5A; mode8 = ~mode8;
         end
         if (!done8 && sum8 !== prev8) stable = 1'b0;
      end
      check({tag, " latency"}, n, 8);
      check({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
      check({tag, " cout"}, {31'd0, cout8}, {31'd0, ec});
      check({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eo});
      check({tag, " sum held"}, {31'd0, stable}, 32'd1);
      @(posedge clk); #1;
      check({tag, " done width"}, {30'd0, done8, busy8}, 32'd0);
      prev8 = es;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;
      int dt [3];
      bit dbl;
      bit last_done;
      bit saw_done;

      start8 = 1'b1; mode8 = 1'b0; a8 = 8'hAA; b8 = 8'h01;
      start4 = 1'b0; mode4 = 1'b0; a4 = 4'h0; b4 = 4'h0;

      // reset held two cycles with Start asserted
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", {31'd0, busy8}, 32'd0);
      check("rst done", {31'd0, done8}, 32'd0);
      check("rst sum", {24'd0, sum8}, 32'd0);
      check("rst cout", {31'd0, cout8}, 32'd0);
      check("rst ovf", {31'd0, ovf8}, 32'd0);
      @(negedge clk);
      rst = 1'b0; start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post-rst idle", {31'd0, busy8}, 32'd0);

      op8("add 100+27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
      op8("add FF+01",  8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0, 1'b0);
      op8("sub 5-7",    8'd5,   8'd7,  1'b1, 8'hFE,  1'b0, 1'b0, 1'b0);
      op8("sub 7-5",    8'd7,   8'd5,  1'b1, 8'h02,  1'b1, 1'b0, 1'b0);
      op8("add mid-change", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1);

      // Start held high: one acceptance every WIDTH+2 cycles
      @(negedge clk);
      a8 = 8'd1; b8 = 8'd2; mode8 = 1'b0; start8 = 1'b1;
      dcount = 0; dbl = 1'b0; last_done = 1'b0;
      dt[0] = -1; dt[1] = -1; dt[2] = -1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (done8) begin
            if (last_done) dbl = 1'b1;
            if (dcount < 3) dt[dcount] = c;
            dcount++;
         end
         last_done = done8;
      end
      @(negedge clk);
      start8 = 1'b0;
      check("hold done count", dcount, 3);
      check("hold done 1st", dt[0], 8);
      check("hold done 2nd", dt[1], 18);
      check("hold done 3rd", dt[2], 28);
      check("hold single pulse", {31'd0, dbl}, 32'd0);
      check("hold sum", {24'd0, sum8}, 32'd3);
      prev8 = 8'd3;

      op8("ovf 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      op8("ovf 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

      // reset lands on the 3rd RUN edge
      @(negedge clk);
      a8 = 8'd50; b8 = 8'd60; mode8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort busy", {31'd0, busy8}, 32'd0);
      check("abort done", {31'd0, done8}, 32'd0);
      check("abort sum", {24'd0, sum8}, 32'd0);
      check("abort cout", {31'd0, cout8}, 32'd0);
      check("abort ovf", {31'd0, ovf8}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done8 || busy8) saw_done = 1'b1;
      end
      check("abort no done", {31'd0, saw_done}, 32'd0);
      prev8 = 8'h00;
      op8("after abort 3+4", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);

      // exhaustive sweep of the 4-bit instance
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int m = 0; m < 2; m++) begin
               logic [3:0] av, bv, bx, es;
               logic [4:0] full;
               logic       ec, eo;
               int         n;
               av = 4'(a); bv = 4'(b);
               bx = (m == 1) ? ~bv : bv;
               full = {1'b0, av} + {1'b0, bx} + 5'(m);
               es = full[3:0];
               ec = full[4];
               eo = (av[3] == bx[3]) && (es[3] != av[3]);
               @(negedge clk);
               a4 = av; b4 = bv; mode4 = 1'(m); start4 = 1'b1;
               @(posedge clk); #1;
               @(negedge clk);
               start4 = 1'b0;
               n = 0;
               while (!done4 && n < 10) begin
                  @(posedge clk); #1;
                  n++;
               end
               check($sformatf("w4 a=%0d b=%0d m=%0d {lat,sum,cout,ovf}", a, b, m),
                     {23'd0, (n == 4), sum4, cout4, ovf4},
                     {23'd0, 1'b1, es, ec, eo});
               @(posedge clk); #1;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
